// File: rtl/score_pkg.sv
// Shared types, segment patterns and BCD helpers for the score counter.
// BCD helpers work on a fixed-width vector of MAX_DIGITS digits. Unused upper
// digits are zero-padded so that values of any width compare correctly.
package score_pkg;

  localparam int unsigned MAX_DIGITS = 6;
  localparam int unsigned BCD_W      = 4 * MAX_DIGITS;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef logic [3:0]       bcd_t;
  typedef logic [BCD_W-1:0] bcd_vec_t;

  // Convert an integer to BCD, keeping only the lowest 'digits' digits
  function automatic bcd_vec_t int_to_bcd(input int value, input int digits);
    bcd_vec_t r;
    int       v;
    r = '0;
    v = value;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (i < digits) r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit-wise a >= b, deciding on the most significant differing digit
  function automatic logic bcd_ge(input bcd_vec_t a, input bcd_vec_t b);
    logic done;
    logic ge;
    done = 1'b0;
    ge   = 1'b1;
    for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
      if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
        ge   = (a[4*i +: 4] > b[4*i +: 4]);
        done = 1'b1;
      end
    end
    return ge;
  endfunction

  // Leading-zero blank mask: digit i > 0 blanks when it and all higher digits are 0
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input bcd_vec_t v, input logic en);
    logic [MAX_DIGITS-1:0] m;
    logic                  nz_seen;
    m       = '0;
    nz_seen = 1'b0;
    for (int i = int'(MAX_DIGITS) - 1; i >= 1; i--) begin
      nz_seen = nz_seen | (v[4*i +: 4] != 4'd0);
      m[i]    = en & ~nz_seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One-digit BCD to active-low 7-segment decoder with blanking.
// Ports:
//   bcd   in  4  BCD digit
//   blank in  1  force all segments off
//   seg   out 7  active-low segments {g..a}; non-BCD codes show blank
module bcd_to_seg7
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_counter_bcd.sv
// Multi-digit saturating BCD score counter with 7-segment outputs.
// Counts rising edges of 'increment', saturates at all 9s, flags the win score.
// Optional high-score tracking is enabled by defining SCORE_HIGH_SCORE_EN.
// Ports:
//   clk        in   1          system clock
//   reset      in   1          synchronous active-high, clears all state
//   clear      in   1          new-game clear of the score (high score kept)
//   increment  in   1          level from game FSM, counted on 0->1 only
//   score_bcd  out  4*DIGITS   current score, digit i at [4i+3:4i]
//   seg        out  7*DIGITS   active-low segments, digit i at [7i+6:7i]
//   win        out  1          score >= WIN_SCORE
//   saturated  out  1          score is all 9s
//   high_bcd   out  4*DIGITS   high score register        (SCORE_HIGH_SCORE_EN)
//   high_seg   out  7*DIGITS   high score segments        (SCORE_HIGH_SCORE_EN)
//   new_high   out  1          score > high score         (SCORE_HIGH_SCORE_EN)
module score_counter_bcd
  import score_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned WIN_SCORE = 10,
  parameter int unsigned BLANK_LZ  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  increment,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  win,
`ifdef SCORE_HIGH_SCORE_EN
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   high_seg,
  output logic                  new_high,
`endif
  output logic                  saturated
);

  localparam int unsigned SCORE_W   = 4 * DIGITS;
  localparam int unsigned MAX_SCORE = (10 ** DIGITS) - 1;
  localparam logic [SCORE_W-1:0] WIN_BCD =
    SCORE_W'(int_to_bcd(int'(WIN_SCORE), int'(DIGITS)));
  localparam logic [SCORE_W-1:0] ALL_NINES =
    SCORE_W'(int_to_bcd(int'(MAX_SCORE), int'(DIGITS)));

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_inc;
  logic               inc_q;
  logic               pulse;
  logic               carry;
  logic [DIGITS-1:0]  blank;

  assign pulse = increment & ~inc_q;

  // Ripple BCD +1: digits at 9 wrap to 0 and pass the carry upward
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Score and edge-detect state; inc_q forced high so a held level never counts
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      inc_q   <= 1'b1;
    end else if (clear) begin
      score_q <= '0;
      inc_q   <= 1'b1;
    end else begin
      inc_q <= increment;
      if (pulse && !saturated) score_q <= score_inc;
    end
  end

  assign score_bcd = score_q;
  assign saturated = (score_q == ALL_NINES);
  assign win       = bcd_ge(BCD_W'(score_q), BCD_W'(WIN_BCD));
  assign blank     = DIGITS'(lz_mask(BCD_W'(score_q), BLANK_LZ != 0));

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .bcd   (score_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg[7*g +: 7])
    );
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic [DIGITS-1:0]  high_blank;

  assign new_high   = ~bcd_ge(BCD_W'(high_q), BCD_W'(score_q));
  assign high_bcd   = high_q;
  assign high_blank = DIGITS'(lz_mask(BCD_W'(high_q), BLANK_LZ != 0));

  // High score follows the score one cycle late; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (new_high) begin
      high_q <= score_q;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_high_seg
    bcd_to_seg7 u_high_seg (
      .bcd   (high_q[4*g +: 4]),
      .blank (high_blank[g]),
      .seg   (high_seg[7*g +: 7])
    );
  end
`endif

endmodule
